// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: one-cold active-low column strobes, synchronized row read-back,
// press/release debounce and one key code per press. Optional auto-repeat: KEYPAD_AUTO_REPEAT_EN.
module keypad_scan_4x4 #(
  parameter logic [15:0] SCAN_DIV     = 16'd50000,
  parameter logic [19:0] DEBOUNCE_CYC = 20'd500000,
  parameter logic [25:0] REPEAT_CYC   = 26'd25000000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // key_valid is a one-cycle strobe with no back-pressure; key_value is stable from that
  // cycle until the next accepted press, so the consumer samples both on the strobe.
  logic [1:0]  state;
  logic [3:0]  row_m;
  logic [3:0]  row_s;
  logic [19:0] cnt;
  logic [1:0]  lat_row;
  logic [1:0]  lat_col;
  logic [1:0]  row_idx;
  logic [1:0]  col_idx;
  logic [3:0]  col_rot;
  logic        lat_bit;
  logic        any_low;
  logic        scan_end;
  logic        deb_end;
  logic        rep_fire;

  // Lowest-index low row wins when several keys in the strobed column are down.
  always_comb begin
    row_idx = 2'd0;
    if (!row_s[0])      row_idx = 2'd0;
    else if (!row_s[1]) row_idx = 2'd1;
    else if (!row_s[2]) row_idx = 2'd2;
    else if (!row_s[3]) row_idx = 2'd3;
  end

  always_comb begin
    col_idx = 2'd0;
    case (col)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  assign col_rot  = {col[2:0], col[3]};
  assign lat_bit  = row_s[lat_row];
  assign any_low  = ~&row_s;
  assign scan_end = (cnt == {4'd0, SCAN_DIV - 16'd1});
  assign deb_end  = (cnt == DEBOUNCE_CYC - 20'd1);

`ifdef KEYPAD_AUTO_REPEAT_EN
  logic [25:0] rep_cnt;
  logic        enter_hold;

  assign enter_hold = ((state == ST_DEBOUNCE) && !lat_bit && deb_end) ||
                      ((state == ST_RELEASE) && !lat_bit);
  assign rep_fire   = (state == ST_HOLD) && !lat_bit && (rep_cnt == REPEAT_CYC - 26'd1);

  // Runs only while the key stays down in HOLD; frozen through RELEASE, cleared on HOLD entry.
  always_ff @(posedge clk) begin
    if (reset_p || enter_hold) begin
      rep_cnt <= 26'd0;
    end else if ((state == ST_HOLD) && !lat_bit) begin
      rep_cnt <= rep_fire ? 26'd0 : rep_cnt + 26'd1;
    end
  end
`else
  // REPEAT_CYC only matters when auto-repeat is built in.
  assign rep_fire = 1'b0 & (REPEAT_CYC == 26'd0);
`endif

  always_ff @(posedge clk) begin
    if (reset_p) begin
      row_m <= 4'b1111;
      row_s <= 4'b1111;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state     <= ST_SCAN;
      cnt       <= 20'd0;
      col       <= 4'b1110;
      lat_row   <= 2'd0;
      lat_col   <= 2'd0;
      key_value <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (scan_end) begin
            cnt <= 20'd0;
            if (any_low) begin
              lat_row <= row_idx;
              lat_col <= col_idx;
              state   <= ST_DEBOUNCE;
            end else begin
              col <= col_rot;
            end
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (lat_bit) begin
            state <= ST_SCAN;
            cnt   <= 20'd0;
            col   <= col_rot;
          end else if (deb_end) begin
            key_value <= {lat_row, lat_col};
            key_valid <= 1'b1;
            state     <= ST_HOLD;
            cnt       <= 20'd0;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
        ST_HOLD: begin
          key_held <= 1'b1;
          if (lat_bit) begin
            cnt   <= 20'd0;
            state <= ST_RELEASE;
          end else if (rep_fire) begin
            key_valid <= 1'b1;
          end
        end
        default: begin
          if (!lat_bit) begin
            state <= ST_HOLD;
            cnt   <= 20'd0;
          end else if (deb_end) begin
            key_held <= 1'b0;
            state    <= ST_SCAN;
            cnt      <= 20'd0;
            col      <= col_rot;
          end else begin
            cnt <= cnt + 20'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4: a physical keypad model drives the rows from the strobed column;
// directed timing scenarios plus randomized presses/taps checked against a key-code scoreboard.
module tb_keypad_scan_4x4;

  localparam int SD       = 4;
  localparam int DB       = 8;
  localparam int RP       = 16;
  localparam int SYNC     = 2;
  // Row released in cycle E: row_s sees it at E+SYNC, RELEASE runs DB cycles after that sample.
  localparam int REL_FALL = SYNC + 1 + DB;

  logic        clk = 1'b0;
  logic        reset_p = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_value;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressed = '0;
  int          cyc = 0;
  int          t0 = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  bit          sb_on = 1'b0;
  int          pulse_cyc_q[$];
  logic [3:0]  pulse_val_q[$];
  logic [3:0]  exp_q[$];

  keypad_scan_4x4 #(
    .SCAN_DIV(16'd4),
    .DEBOUNCE_CYC(20'd8),
    .REPEAT_CYC(26'd16)
  ) dut (
    .clk(clk),
    .reset_p(reset_p),
    .row(row),
    .col(col),
    .key_value(key_value),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Keypad: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (col[c] == 1'b0)) row[r] = 1'b0;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      pulse_cyc_q.push_back(cyc - t0);
      pulse_val_q.push_back(key_value);
      if (sb_on) begin
        if (exp_q.size() == 0) check("sb_unexpected_pulse", 32'd1, 32'd0);
        else check("sb_key", key_value, exp_q.pop_front());
      end
    end
  end

  task automatic check_pulses(input string tag, input int exp_cyc[$], input logic [3:0] exp_val);
    check({tag, "_count"}, pulse_cyc_q.size(), exp_cyc.size());
    for (int i = 0; i < exp_cyc.size() && i < pulse_cyc_q.size(); i++) begin
      check({tag, "_cyc"}, pulse_cyc_q[i], exp_cyc[i]);
      check({tag, "_val"}, pulse_val_q[i], exp_val);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc - t0 < n) tick();
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    tick();
    reset_p = 1'b0;
    t0 = cyc;
    pulse_cyc_q.delete();
    pulse_val_q.delete();
  endtask

  function automatic logic [3:0] col_strobe(input int idx);
    logic [3:0] v;
    v = 4'b1111;
    v[idx % 4] = 1'b0;
    return v;
  endfunction

  // Key held since reset in column c: sampled at the end of that column's dwell, then debounced.
  function automatic int acc_cyc(input int c);
    return SD * (c + 1) + DB;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int q[$];
    int acc;
    int rel;
    int k;
    int tmo;

    // Reset and idle scanning
    pressed = '0;
    do_reset();
    check("rst_col", col, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    check("rst_value", key_value, 4'h0);
    for (int n = 0; n < 20; n++) begin
      wait_until(n);
      check("idle_col", col, col_strobe((n / SD) % 4));
    end
    check("idle_pulses", pulse_cyc_q.size(), 0);

    // Single press: row 2, col 1 -> code 9
    pressed = '0;
    pressed[9] = 1'b1;
    do_reset();
    acc = acc_cyc(1);
    wait_until(acc);
    check("press_held_at_valid", key_held, 1'b0);
    wait_until(acc + 1);
    check("press_held_after", key_held, 1'b1);
    q = {};
    q.push_back(acc);
    check_pulses("press", q, 4'h9);
    rel = acc + 4;
    wait_until(rel);
    pressed[9] = 1'b0;
    wait_until(rel + 5);
    check("press_col_frozen", col, col_strobe(1));
    wait_until(rel + REL_FALL - 1);
    check("press_held_release", key_held, 1'b1);
    wait_until(rel + REL_FALL);
    check("press_held_fall", key_held, 1'b0);
    check("press_resume_col", col, col_strobe(2));

    // Bounce: row_s goes high on the 5th debounce cycle
    pressed = '0;
    pressed[0] = 1'b1;
    do_reset();
    wait_until(SD + 4 - SYNC);
    pressed[0] = 1'b0;
    wait_until(SD + 4);
    check("bounce_col_frozen", col, col_strobe(0));
    wait_until(SD + 5);
    check("bounce_col_next", col, col_strobe(1));
    wait_until(SD + 5 + SD);
    check("bounce_col_scan", col, col_strobe(2));
    wait_until(40);
    check("bounce_pulses", pulse_cyc_q.size(), 0);
    check("bounce_held", key_held, 1'b0);

    // Reset on debounce cycle 4 of a key in column 1
    pressed = '0;
    pressed[1] = 1'b1;
    do_reset();
    wait_until(SD * 2 + 3);
    check("mid_rst_pre_col", col, col_strobe(1));
    do_reset();
    check("mid_rst_col", col, 4'b1110);
    check("mid_rst_held", key_held, 1'b0);
    check("mid_rst_valid", key_valid, 1'b0);
    acc = acc_cyc(1);
    wait_until(acc + 1);
    q = {};
    q.push_back(acc);
    check_pulses("mid_rst_repress", q, 4'h1);
    pressed[1] = 1'b0;
    wait_until(acc + 1 + REL_FALL);
    check("mid_rst_release", key_held, 1'b0);

    // Simultaneous rows 0 and 1 on column 0, then a glitch during release
    pressed = '0;
    pressed[0] = 1'b1;
    pressed[4] = 1'b1;
    do_reset();
    acc = acc_cyc(0);
    wait_until(acc + 1);
    q = {};
    q.push_back(acc);
    check_pulses("simul", q, 4'h0);
    rel = acc + 2;
    wait_until(rel);
    pressed = '0;
    wait_until(rel + 6);
    pressed[0] = 1'b1;
    wait_until(rel + 9);
    pressed[0] = 1'b0;
    foreach (q[i]) begin end
    wait_until(rel + 8);
    check("glitch_held_a", key_held, 1'b1);
    wait_until(rel + REL_FALL);
    check("glitch_held_b", key_held, 1'b1);
    wait_until(rel + 9 + REL_FALL - 1);
    check("glitch_held_c", key_held, 1'b1);
    wait_until(rel + 9 + REL_FALL);
    check("glitch_held_fall", key_held, 1'b0);
    check("glitch_pulses", pulse_cyc_q.size(), 1);

    // Long hold of key 5
    pressed = '0;
    pressed[5] = 1'b1;
    do_reset();
    acc = acc_cyc(1);
    rel = acc + 60;
    wait_until(rel);
    pressed[5] = 1'b0;
    wait_until(rel + REL_FALL);
    check("hold_release", key_held, 1'b0);
    q = {};
`ifdef KEYPAD_AUTO_REPEAT_EN
    for (int p = acc; p <= rel + SYNC; p += RP) q.push_back(p);
`else
    q.push_back(acc);
`endif
    check_pulses("hold", q, 4'h5);

    // Randomized presses and short taps against the scoreboard
    pressed = '0;
    do_reset();
    sb_on = 1'b1;
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) begin
        pressed[k] = 1'b1;
        repeat ($urandom_range(1, 6)) tick();
        pressed[k] = 1'b0;
        repeat (SYNC + 2) tick();
      end else begin
        exp_q.push_back(k[3:0]);
        pressed[k] = 1'b1;
        tmo = 1;
        for (int w = 0; w < 100; w++) begin
          if (key_held === 1'b1) begin
            tmo = 0;
            break;
          end
          tick();
        end
        check("rand_press_timeout", tmo, 0);
        repeat ($urandom_range(0, 8)) tick();
        pressed[k] = 1'b0;
        tmo = 1;
        for (int w = 0; w < 40; w++) begin
          if (key_held === 1'b0) begin
            tmo = 0;
            break;
          end
          tick();
        end
        check("rand_release_timeout", tmo, 0);
      end
      repeat ($urandom_range(0, 6)) tick();
    end
    repeat (4) tick();
    sb_on = 1'b0;
    check("sb_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
